gcd_job_sequencer: RTL and testbench

- Upstream feeder for the GCD datapath/controller pair.
- Accepts operand pairs on a valid/ready stream and clears the core once per job.
- Drives the core's shared input bus, A then B, around the start pulse; waits for done and returns the result on a valid/ready output stream.
- Bypasses the core for zero operands, which would never converge, and flags a timeout if done never arrives.

---
 rtl/gcd_pkg.sv | 17 +
 rtl/gcd_timeout_counter.sv | 32 +++
 rtl/gcd_job_sequencer.sv | 132 +++++++++++++
 tb/tb_gcd_job_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD job sequencer.
// The state enum is common to the sequencer FSM and to anything that inspects it.
package gcd_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    LOAD_A = 3'd2,
    LOAD_B = 3'd3,
    WAIT   = 3'd4,
    RESP   = 3'd5
  } seq_state_t;

  localparam int GCD_WIDTH   = 8;
  localparam int GCD_TIMEOUT = 512;

endpackage

// File: rtl/gcd_timeout_counter.sv
// Saturating cycle counter for the WAIT state.
// The expired flag is raised while the count sits at LIMIT-1, i.e. on the LIMIT-th enabled cycle.
module gcd_timeout_counter
  import gcd_pkg::*;
#(
  parameter int LIMIT = GCD_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != CW'(LIMIT))) begin
      // Stops at LIMIT so a stuck enable can never wrap back to a fresh count.
      count_reg <= count_reg + CW'(1);
    end
  end

  assign expired = (count_reg == CW'(LIMIT - 1));

endmodule

// File: rtl/gcd_job_sequencer.sv
// Feeds operand pairs to the GCD core: clear, load A with start, load B, wait for done.
// Zero operands bypass the core; a missing done produces a timeout result.
module gcd_job_sequencer
  import gcd_pkg::*;
#(
  parameter int WIDTH          = GCD_WIDTH,
  parameter int TIMEOUT_CYCLES = GCD_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_timeout,
  output logic             core_clr,
  output logic             core_start,
  output logic [WIDTH-1:0] core_data,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_result,
  output logic             busy
);

  seq_state_t       state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] gcd_reg, gcd_next;
  logic             timeout_reg, timeout_next;
  logic             expired;

  gcd_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_reg != WAIT),
    .enable  (state_reg == WAIT),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      gcd_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      gcd_reg     <= gcd_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    gcd_next     = gcd_reg;
    timeout_next = timeout_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          a_next = in_a;
          b_next = in_b;
          if ((in_a == '0) || (in_b == '0)) begin
            // gcd(0,x) = x and gcd(0,0) = 0; the core would never converge here.
            gcd_next     = in_a | in_b;
            timeout_next = 1'b0;
            state_next   = RESP;
          end else begin
            state_next = CLR;
          end
        end
      end
      CLR:    state_next = LOAD_A;
      LOAD_A: state_next = LOAD_B;
      LOAD_B: state_next = WAIT;
      WAIT: begin
        if (core_done) begin
          gcd_next     = core_result;
          timeout_next = 1'b0;
          state_next   = RESP;
        end else if (expired) begin
          gcd_next     = '0;
          timeout_next = 1'b1;
          state_next   = RESP;
        end
      end
      RESP: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_gcd     = '0;
    out_timeout = 1'b0;
    core_clr    = 1'b0;
    core_start  = 1'b0;
    core_data   = '0;
    busy        = (state_reg != IDLE);
    case (state_reg)
      IDLE: in_ready = 1'b1;
      CLR: begin
        core_clr  = 1'b1;
        core_data = a_reg;
      end
      LOAD_A: begin
        core_start = 1'b1;
        core_data  = a_reg;
      end
      LOAD_B: core_data = b_reg;
      WAIT:   core_data = b_reg;
      RESP: begin
        out_valid   = 1'b1;
        out_gcd     = gcd_reg;
        out_timeout = timeout_reg;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Bench for gcd_job_sequencer: subtractive core model, result scoreboard, and a
// small second instance with a 16-cycle timeout whose core never finishes.
module tb_gcd_job_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_timeout;
  logic [7:0] in_a = '0, in_b = '0, out_gcd, core_data, core_result;
  logic       core_clr, core_start, core_done, busy;

  logic       t_in_valid = 1'b0, t_in_ready, t_out_valid, t_out_timeout;
  logic       t_core_clr, t_core_start, t_busy;
  logic [3:0] t_in_a = '0, t_in_b = '0, t_out_gcd, t_core_data;
  logic       t_out_ready = 1'b1;
  logic       t_core_done = 1'b0;
  logic [3:0] t_core_result = 4'd9;

  gcd_job_sequencer #(.WIDTH(8), .TIMEOUT_CYCLES(512)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_gcd(out_gcd), .out_timeout(out_timeout), .core_clr(core_clr),
    .core_start(core_start), .core_data(core_data), .core_done(core_done),
    .core_result(core_result), .busy(busy)
  );

  gcd_job_sequencer #(.WIDTH(4), .TIMEOUT_CYCLES(16)) dut_to (
    .clk(clk), .rst_n(rst_n), .in_valid(t_in_valid), .in_ready(t_in_ready),
    .in_a(t_in_a), .in_b(t_in_b), .out_valid(t_out_valid), .out_ready(t_out_ready),
    .out_gcd(t_out_gcd), .out_timeout(t_out_timeout), .core_clr(t_core_clr),
    .core_start(t_core_start), .core_data(t_core_data), .core_done(t_core_done),
    .core_result(t_core_result), .busy(t_busy)
  );

  // Core model: load A on start, B on the next cycle, then subtract until equal.
  logic [7:0] ca = '0, cb = '0;
  logic [1:0] cphase = 2'd0;
  always @(posedge clk) begin
    if (core_clr) cphase <= 2'd0;
    else case (cphase)
      2'd0: if (core_start) begin ca <= core_data; cphase <= 2'd1; end
      2'd1: begin cb <= core_data; cphase <= 2'd2; end
      2'd2: if (ca == cb) cphase <= 2'd3;
            else if (ca > cb) ca <= ca - cb;
            else cb <= cb - ca;
      default: ;
    endcase
  end
  assign core_done   = (cphase == 2'd3);
  assign core_result = ca;

  typedef struct { logic [7:0] g; logic t; } exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0, results = 0, clr_cnt = 0, start_cnt = 0;

  function automatic logic [7:0] gcd_ref(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, y, r;
    x = a; y = b;
    while (y != 0) begin r = x % y; x = y; y = r; end
    return x;
  endfunction

  always @(negedge clk) begin
    if (core_clr) clr_cnt++;
    if (core_start) start_cnt++;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got gcd=%0d timeout=%0b, required no result", out_gcd, out_timeout);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_gcd !== e.g || out_timeout !== e.t) begin
          errors++;
          $display("FAIL result: got gcd=%0d timeout=%0b, required gcd=%0d timeout=%0b", out_gcd, out_timeout, e.g, e.t);
        end else
          $display("result gcd=%0d timeout=%0b", out_gcd, out_timeout);
      end
      results++;
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input bit hold);
    int n = 0;
    exp_t e;
    in_a = a; in_b = b; in_valid = 1'b1;
    while (!in_ready && n < 2000) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready=%0b, required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.g = gcd_ref(a, b); e.t = 1'b0;
    exp_q.push_back(e);
    $display("send a=%0d b=%0d", a, b);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 2000) begin @(posedge clk); #1; n++; end
    checks++;
    if (busy || exp_q.size() != 0) begin
      errors++;
      $display("FAIL idle_timeout: busy=%0b pending=%0d, required 0/0", busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({out_valid, out_gcd, out_timeout, core_clr, core_start, core_data, busy, t_out_valid, t_busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b gcd=%0d clr=%0b start=%0b data=%0d busy=%0b, required all 0",
               out_valid, out_gcd, core_clr, core_start, core_data, busy);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || t_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: in_ready=%0b busy=%0b, required 1/0", in_ready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int r0 = results, s0 = start_cnt;
    out_ready = 1'b1;
    send(8'd12, 8'd18, 1'b0);
    checks++;
    if (core_clr !== 1'b1 || core_start !== 1'b0 || core_data !== 8'd12) begin
      errors++;
      $display("FAIL clr_phase: clr=%0b start=%0b data=%0d, required 1/0/12", core_clr, core_start, core_data);
    end
    @(posedge clk); #1;
    checks++;
    if (core_start !== 1'b1 || core_clr !== 1'b0 || core_data !== 8'd12) begin
      errors++;
      $display("FAIL start_phase: clr=%0b start=%0b data=%0d, required 0/1/12", core_clr, core_start, core_data);
    end
    @(posedge clk); #1;
    checks++;
    if (core_start !== 1'b0 || core_clr !== 1'b0 || core_data !== 8'd18) begin
      errors++;
      $display("FAIL load_b_phase: clr=%0b start=%0b data=%0d, required 0/0/18", core_clr, core_start, core_data);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || core_data !== 8'd18 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL wait_phase: busy=%0b data=%0d valid=%0b, required 1/18/0", busy, core_data, out_valid);
    end
    wait_idle();
    checks++;
    if (results != r0 + 1 || start_cnt != s0 + 1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_counts: results=%0d starts=%0d in_ready=%0b, required 1/1/1", results - r0, start_cnt - s0, in_ready);
    end
  endtask

  task automatic test_zero();
    int c0 = clr_cnt, s0 = start_cnt;
    out_ready = 1'b1;
    send(8'd0, 8'd7, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_gcd !== 8'd7 || out_timeout !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_bypass: valid=%0b gcd=%0d to=%0b in_ready=%0b, required 1/7/0/0", out_valid, out_gcd, out_timeout, in_ready);
    end
    wait_idle();
    send(8'd0, 8'd0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_gcd !== 8'd0 || out_timeout !== 1'b0) begin
      errors++;
      $display("FAIL zero_zero: valid=%0b gcd=%0d to=%0b, required 1/0/0", out_valid, out_gcd, out_timeout);
    end
    wait_idle();
    checks++;
    if (clr_cnt != c0 || start_cnt != s0) begin
      errors++;
      $display("FAIL zero_core_untouched: clr=%0d start=%0d, required 0/0", clr_cnt - c0, start_cnt - s0);
    end
  endtask

  task automatic test_stall();
    int n = 0;
    out_ready = 1'b0;
    send(8'd255, 8'd1, 1'b0);
    while (!out_valid && n < 1000) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_gcd !== 8'd1 || out_timeout !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid=%0b gcd=%0d to=%0b in_ready=%0b, required 1/1/0/0",
                 i, out_valid, out_gcd, out_timeout, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_idle();
  endtask

  task automatic test_timeout();
    int n = 0;
    t_in_a = 4'd3; t_in_b = 4'd5; t_in_valid = 1'b1;
    @(posedge clk); #1;
    t_in_valid = 1'b0;
    while (!t_out_valid && n < 100) begin @(posedge clk); #1; n++; end
    $display("timeout job a=3 b=5 latency=%0d gcd=%0d timeout=%0b", n, t_out_gcd, t_out_timeout);
    checks++;
    if (n != 19 || t_out_gcd !== 4'd0 || t_out_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_result: latency=%0d gcd=%0d to=%0b, required 19/0/1", n, t_out_gcd, t_out_timeout);
    end
    @(posedge clk); #1;
    checks++;
    if (t_busy !== 1'b0 || t_in_ready !== 1'b1 || t_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_return: busy=%0b in_ready=%0b valid=%0b, required 0/1/0", t_busy, t_in_ready, t_out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int c0 = clr_cnt, r0 = results;
    out_ready = 1'b1;
    send(8'd9, 8'd6, 1'b1);
    send(8'd7, 8'd5, 1'b0);
    wait_idle();
    checks++;
    if (clr_cnt != c0 + 2 || results != r0 + 2) begin
      errors++;
      $display("FAIL back_to_back: clr_pulses=%0d results=%0d, required 2/2", clr_cnt - c0, results - r0);
    end
  endtask

  task automatic test_reset_mid_job();
    int r0;
    bit saw = 1'b0;
    out_ready = 1'b1;
    send(8'd100, 8'd75, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (busy !== 1'b1 || core_data !== 8'd75 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_wait: busy=%0b data=%0d valid=%0b, required 1/75/0", busy, core_data, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_gcd, out_timeout, core_clr, core_start, core_data, busy} !== '0) begin
      errors++;
      $display("FAIL async_reset: valid=%0b gcd=%0d data=%0d busy=%0b, required all 0", out_valid, out_gcd, core_data, busy);
    end
    exp_q.delete();
    r0 = results;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (20) begin @(posedge clk); #1; if (out_valid) saw = 1'b1; end
    checks++;
    if (saw || results != r0) begin
      errors++;
      $display("FAIL abandoned_job: saw_valid=%0b results=%0d, required 0/0", saw, results - r0);
    end
    send(8'd8, 8'd12, 1'b0);
    wait_idle();
    checks++;
    if (results != r0 + 1) begin
      errors++;
      $display("FAIL post_reset_job: results=%0d, required 1", results - r0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_stall();
    test_timeout();
    test_back_to_back();
    test_reset_mid_job();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
